// File: rtl/aes128_enc_iter.sv
// rtl/aes128_enc_iter.sv - iterative AES-128 encryptor, one round per clock
//
// Purpose: AES-128 forward cipher. It runs one round per clock and expands the
// round keys on the fly. A block takes 10 rounds after the accepting edge.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   in_valid   message/key are presented (sampled only in IDLE)
//   in_ready   high only in IDLE
//   message    plaintext [0:127], bits 0:7 are byte 0, column-major
//   key        cipher key, same byte order as message
//   out_valid  high only in DONE; crypte holds the ciphertext
//   out_ready  consumer takes crypte (sampled only in DONE)
//   crypte     ciphertext, driven straight from the state register
module aes128_enc_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] message,
    input  logic [0:127] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] crypte
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // Forward S-box. Entry x sits at bits [2047-8x -: 8], so byte 0x00 is the
    // leftmost byte of the first row.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // 2047 - 8*x is {~x, 3'b111}; this avoids integer-width arithmetic.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Internal 128-bit words are [127:0] with byte 0 at [127:120]. Byte i is
    // row i%4 of column i/4.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    // Row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c    -: 8];
            a1 = s[127-32*c-8  -: 8];
            a2 = s[127-32*c-16 -: 8];
            a3 = s[127-32*c-24 -: 8];
            o[127-32*c    -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[127-32*c-8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[127-32*c-16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[127-32*c-24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon_for(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // One step of the AES-128 key schedule. These are the only four S-box
    // lookups on the key path.
    function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7, t;
        w0 = rk[127:96];
        w1 = rk[95:64];
        w2 = rk[63:32];
        w3 = rk[31:0];
        // SubWord(RotWord(w3)): rotate bytes left by one, then substitute.
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w4 = w0 ^ t ^ {rc, 24'h000000};
        w5 = w1 ^ w4;
        w6 = w2 ^ w5;
        w7 = w3 ^ w6;
        return {w4, w5, w6, w7};
    endfunction

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rkey_q, rkey_d;
    logic [3:0]   round_q, round_d;

    logic [127:0] msg_w, key_w;
    logic [7:0]   rcon;
    logic [127:0] next_key, sb_out, sr_out, mc_out, round_out;

    assign msg_w = message;
    assign key_w = key;

    // Round datapath. Round 10 is the last round and skips MixColumns.
    always_comb begin
        rcon      = rcon_for(round_q);
        next_key  = key_expand(rkey_q, rcon);
        sb_out    = sub_bytes(state_q);
        sr_out    = shift_rows(sb_out);
        mc_out    = mix_columns(sr_out);
        round_out = ((round_q == 4'd10) ? sr_out : mc_out) ^ next_key;
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rkey_d  = rkey_q;
        round_d = round_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = msg_w ^ key_w;
                    rkey_d  = key_w;
                    round_d = 4'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                state_d = round_out;
                rkey_d  = next_key;
                // The counter parks at 10 after the last round; it never reaches 11.
                if (round_q == 4'd10) begin
                    fsm_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rkey_q  <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rkey_q  <= rkey_d;
            round_q <= round_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign crypte    = state_q;

endmodule
